// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM datapath blocks: FSM state encoding of the final subtractor.
package iddmm_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StLoad  = 2'd0;
   localparam state_t StDrain = 2'd1;
   localparam state_t StEmit  = 2'd2;

endpackage

// File: rtl/iddmm_word_sub.sv
// One K-bit step of a word-serial subtract chain; the borrow between words is the registered state.
module iddmm_word_sub #(
   parameter int unsigned K = 128
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_first,
   input  logic [K-1:0] i_a,
   input  logic [K-1:0] i_b,
   output logic [K-1:0] o_d,
   output logic         o_borrow
);

   logic         r_borrow;
   logic         w_bin;
   logic [K:0]   w_diff;

   always_comb begin
      w_bin  = i_first ? 1'b0 : r_borrow;
      w_diff = {1'b0, i_a} - {1'b0, i_b} - {{K{1'b0}}, w_bin};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_borrow <= 1'b0;
      end else if (i_en) begin
         r_borrow <= w_diff[K];
      end
   end

   assign o_d      = w_diff[K-1:0];
   assign o_borrow = r_borrow;

endmodule

// File: rtl/iddmm_final_sub.sv
// Word-serial conditional final subtraction: buffers T and T-M, then streams whichever is < M.
module iddmm_final_sub
   import iddmm_pkg::*;
#(
   parameter int unsigned K      = 128,
   parameter int unsigned N      = 32,
   parameter int unsigned ADDR_W = $clog2(N)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [K-1:0]      i_in_data,
   input  logic              i_in_top,
   output logic [ADDR_W-1:0] o_m_addr,
   input  logic [K-1:0]      i_m_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [K-1:0]      o_out_data,
   output logic              o_out_last,
   output logic              o_sub_sel
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_j;
   logic [ADDR_W-1:0]   r_rd;
   logic [ADDR_W-1:0]   r_idx1;
   logic [K-1:0]        r_t1;
   logic                r_v1;
   logic                r_top;
   logic                r_sub_sel;
   logic [K-1:0]        r_out_data;
   logic [K-1:0]        r_tbuf [N];
   logic [K-1:0]        r_dbuf [N];

   logic                w_accept;
   logic                w_last_in;
   logic                w_out_hs;
   logic                w_last_out;
   logic                w_drain_done;
   logic                w_sel_nxt;
   logic                w_sel_use;
   logic [ADDR_W-1:0]   w_rd_nxt;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [K-1:0]        w_rd_word;
   logic [K-1:0]        w_d;
   logic                w_borrow;

   assign w_accept     = (r_state == StLoad) && i_in_valid;
   assign w_last_in    = w_accept && (r_j == LastIdx);
   assign w_out_hs     = (r_state == StEmit) && i_out_ready;
   assign w_last_out   = w_out_hs && (r_rd == LastIdx);
   // DRAIN waits while stage 2 still holds the last word, so its borrow is final on exit.
   assign w_drain_done = (r_state == StDrain) && !r_v1;
   assign w_sel_nxt    = r_top | ~w_borrow;
   assign w_rd_nxt     = r_rd + ADDR_W'(1);

   // Prefetch the next output word so EMIT streams without bubbles.
   always_comb begin
      w_rd_addr = w_drain_done ? '0 : w_rd_nxt;
      w_sel_use = w_drain_done ? w_sel_nxt : r_sub_sel;
      w_rd_word = w_sel_use ? r_dbuf[w_rd_addr] : r_tbuf[w_rd_addr];
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StLoad:  if (w_last_in)    w_state_nxt = StDrain;
         StDrain: if (w_drain_done) w_state_nxt = StEmit;
         StEmit:  if (w_last_out)   w_state_nxt = StLoad;
         default: w_state_nxt = StLoad;
      endcase
   end

   iddmm_word_sub #(
      .K (K)
   ) u_word_sub (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (w_last_out),
      .i_en     (r_v1),
      .i_first  (r_idx1 == '0),
      .i_a      (r_t1),
      .i_b      (i_m_data),
      .o_d      (w_d),
      .o_borrow (w_borrow)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StLoad;
         r_j        <= '0;
         r_rd       <= '0;
         r_idx1     <= '0;
         r_t1       <= '0;
         r_v1       <= 1'b0;
         r_top      <= 1'b0;
         r_sub_sel  <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_v1    <= w_accept;
         if (w_accept) begin
            r_t1   <= i_in_data;
            r_idx1 <= r_j;
            r_j    <= (r_j == LastIdx) ? '0 : r_j + ADDR_W'(1);
            if (r_j == LastIdx) begin
               r_top <= i_in_top;
            end
         end
         if (w_drain_done) begin
            r_sub_sel  <= w_sel_nxt;
            r_rd       <= '0;
            r_out_data <= w_rd_word;
         end
         if (w_out_hs) begin
            r_rd <= w_last_out ? '0 : w_rd_nxt;
            if (!w_last_out) begin
               r_out_data <= w_rd_word;
            end
         end
         if (w_last_out) begin
            r_j <= '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (r_v1) begin
         r_tbuf[r_idx1] <= r_t1;
         r_dbuf[r_idx1] <= w_d;
      end
   end

   assign o_in_ready  = (r_state == StLoad);
   assign o_m_addr    = r_j;
   assign o_out_valid = (r_state == StEmit);
   assign o_out_data  = r_out_data;
   assign o_out_last  = (r_state == StEmit) && (r_rd == LastIdx);
   assign o_sub_sel   = r_sub_sel;

endmodule

// File: tb/tb_iddmm_final_sub.sv
// Randomised bench for iddmm_final_sub with K=8, N=2 and M=0x0105 against an arithmetic reference.
module tb_iddmm_final_sub;

   localparam int unsigned K = 8;
   localparam int unsigned N = 2;
   localparam logic [16:0] Mod = 17'h00105;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] in_data;
   logic         in_top;
   logic [0:0]   m_addr;
   logic [K-1:0] m_data;
   logic         out_valid;
   logic         out_ready;
   logic [K-1:0] out_data;
   logic         out_last;
   logic         sub_sel;

   logic [K-1:0] mem [N];

   int n_cmp;
   int n_bad;

   iddmm_final_sub #(
      .K (K),
      .N (N)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .i_in_top    (in_top),
      .o_m_addr    (m_addr),
      .i_m_data    (m_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_sub_sel   (sub_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Modulus RAM with one cycle of read latency.
   always_ff @(posedge clk) begin
      m_data <= mem[m_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {sub_sel, result}: T - M if T >= M, else T, truncated to N*K bits.
   function automatic logic [16:0] ref_model(input logic [7:0] t0, input logic [7:0] t1,
                                             input logic top);
      logic [16:0] t;
      logic [16:0] r;
      t = {top, t1, t0};
      if (t >= Mod) begin
         r = t - Mod;
         return {1'b1, r[15:0]};
      end
      return {1'b0, t[15:0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_sub_sel", 32'(sub_sel), 32'd0);
      chk("rst_m_addr", 32'(m_addr), 32'd0);
      rst = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] t0, input logic [7:0] t1, input logic top,
                         input bit gaps, input bit stalls, input bit chk_lat, input bit abort);
      logic [16:0] exp;
      logic [7:0]  w_in [2];
      logic [7:0]  w_exp [2];
      int          idx_in;
      int          idx_out;
      int          cyc;
      int          first_acc;
      int          first_out;
      exp       = ref_model(t0, t1, top);
      w_in[0]   = t0;
      w_in[1]   = t1;
      w_exp[0]  = exp[7:0];
      w_exp[1]  = exp[15:8];
      idx_in    = 0;
      idx_out   = 0;
      cyc       = 0;
      first_acc = -1;
      first_out = -1;
      while (idx_out < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            if (first_out < 0) first_out = cyc;
            if (abort) break;
            chk("no_in_emit", 32'(in_ready), 32'd0);
            chk("out_data", 32'(out_data), 32'(w_exp[idx_out]));
            chk("out_last", 32'(out_last), 32'(idx_out == 1));
            chk("sub_sel", 32'(sub_sel), 32'(exp[16]));
         end
         if (idx_in < 2) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = w_in[idx_in];
            in_top   = (idx_in == 1) ? top : 1'($urandom);
            if (in_valid && in_ready) begin
               if (first_acc < 0) first_acc = cyc;
               idx_in++;
            end
         end else begin
            in_valid = gaps ? 1'($urandom) : 1'b0;
            in_data  = 8'($urandom);
            in_top   = 1'($urandom);
         end
         out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (out_valid && out_ready) idx_out++;
      end
      if (chk_lat) chk("latency", 32'(first_out - first_acc), 32'd4);
      if (!abort) chk("op_done", 32'(idx_out), 32'd2);
   endtask

   logic [7:0] dir_t0  [8] = '{8'h10, 8'h00, 8'h05, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'h06};
   logic [7:0] dir_t1  [8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01};
   logic       dir_top [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [15:0] tv;
      n_cmp     = 0;
      n_bad     = 0;
      mem[0]    = 8'h05;
      mem[1]    = 8'h01;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_top    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         run_op(dir_t0[i], dir_t1[i], dir_top[i], 1'b0, 1'b0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 30; i++) begin
         tv = 16'($urandom);
         if ($urandom_range(0, 3) == 0) tv = 16'(16'h0104 + $urandom_range(0, 2));
         run_op(tv[7:0], tv[15:8], ($urandom_range(0, 3) == 0), 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // Reset after word 0 has been accepted.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_top   = 1'b1;
      do_reset();
      run_op(8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset while the first result word is waiting in EMIT.
      run_op(8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b0;
      do_reset();
      run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
